// File: rtl/note_sequencer.sv
`default_nettype none
// =============================================================================
// note_sequencer : event FIFO + tempo divider + playback FSM driving noteStream.
// Optional macro NOTE_SEQUENCER_GAP_EN inserts a one-tick rest after each note.
// Revision: 1.0
// =============================================================================
module note_sequencer #(
    parameter int DEPTH  = 8,
    parameter int DUR_W  = 8,
    parameter int TICK_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TICK_W-1:0] tick_div,
    input  logic              start,
    input  logic              stop,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic [8:0]        ev_note,
    input  logic [DUR_W-1:0]  ev_dur,
    output logic [8:0]        noteStream,
    output logic              note_on,
    output logic              busy,
    output logic              underrun
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = 9 + DUR_W;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    state_t            r_state;
    logic              r_start_q;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [TICK_W-1:0] r_tdiv_m1;
    logic [DUR_W-1:0]  r_dur_cnt;

    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_play_end;
    logic [CW-1:0]     w_count_nxt;
    logic [EW-1:0]     w_head;
    logic [8:0]        w_code;
    logic [DUR_W-1:0]  w_dur_m1;
    logic [TICK_W-1:0] w_tdiv_m1;

    // Out-of-range octave or note (including 0) collapses to a rest.
    function automatic logic [8:0] f_validate(input logic [8:0] code);
        logic oct_ok;
        logic note_ok;
        oct_ok  = (code[8:6] >= 3'd2) && (code[8:6] <= 3'd6);
        note_ok = (code[5:0] >= 6'd1) && (code[5:0] <= 6'd12);
        return (oct_ok && note_ok) ? code : 9'd0;
    endfunction

    assign w_empty     = (r_count == '0);
    assign w_push      = ev_valid && ev_ready && !stop;
    assign w_play_end  = (r_state == PLAY) && (r_tick_cnt == '0) && (r_dur_cnt == '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_code      = f_validate(w_head[8:0]);
    assign w_dur_m1    = (w_head[EW-1:9] == '0) ? '0 : w_head[EW-1:9] - DUR_W'(1);
    assign w_tdiv_m1   = (tick_div == '0) ? '0 : tick_div - TICK_W'(1);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

`ifdef NOTE_SEQUENCER_GAP_EN
    logic w_gap_end;
    assign w_gap_end = (r_state == GAP) && (r_tick_cnt == '0);
    assign w_pop     = !stop && !w_empty && ((r_state == FETCH) || w_gap_end);
`else
    assign w_pop     = !stop && !w_empty && ((r_state == FETCH) || w_play_end);
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {ev_dur, ev_note};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_start_q  <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            ev_ready   <= 1'b1;
            r_tick_cnt <= '0;
            r_tdiv_m1  <= '0;
            r_dur_cnt  <= '0;
            noteStream <= 9'd0;
            note_on    <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else if (stop) begin
            r_state    <= IDLE;
            r_start_q  <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            ev_ready   <= 1'b1;
            noteStream <= 9'd0;
            note_on    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count   <= w_count_nxt;
            ev_ready  <= (w_count_nxt != C_FULL);
            r_start_q <= 1'b0;

            case (r_state)
                IDLE: begin
                    // start is registered once, so the first FETCH lands a cycle later.
                    if (r_start_q) begin
                        r_state <= FETCH;
                    end else if (start) begin
                        r_start_q <= 1'b1;
                        busy      <= 1'b1;
                        underrun  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (w_empty) begin
                        underrun <= 1'b1;
                    end
                end
                PLAY: begin
                    if (r_tick_cnt == '0) begin
                        r_tick_cnt <= r_tdiv_m1;
                        if (r_dur_cnt != '0) begin
                            r_dur_cnt <= r_dur_cnt - DUR_W'(1);
                        end else begin
                            noteStream <= 9'd0;
                            note_on    <= 1'b0;
`ifdef NOTE_SEQUENCER_GAP_EN
                            r_state    <= GAP;
`else
                            if (w_empty) begin
                                r_state  <= FETCH;
                                underrun <= 1'b1;
                            end
`endif
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt - TICK_W'(1);
                    end
                end
                GAP: begin
                    if (r_tick_cnt == '0) begin
                        r_state <= FETCH;
                    end else begin
                        r_tick_cnt <= r_tick_cnt - TICK_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A pop always loads the next note and overrides the state updates above.
            if (w_pop) begin
                r_state    <= PLAY;
                noteStream <= w_code;
                note_on    <= (w_code != 9'd0);
                r_tick_cnt <= w_tdiv_m1;
                r_tdiv_m1  <= w_tdiv_m1;
                r_dur_cnt  <= w_dur_m1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// =============================================================================
// tb_note_sequencer : directed and randomized playback checked against a
// note-timeline reference model. Revision: 1.0
// =============================================================================
module tb_note_sequencer;
    localparam int DEPTH  = 8;
    localparam int DUR_W  = 8;
    localparam int TICK_W = 24;
`ifdef NOTE_SEQUENCER_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [TICK_W-1:0] tick_div;
    logic              start;
    logic              stop;
    logic              ev_valid;
    logic              ev_ready;
    logic [8:0]        ev_note;
    logic [DUR_W-1:0]  ev_dur;
    logic [8:0]        noteStream;
    logic              note_on;
    logic              busy;
    logic              underrun;

    int n_assert = 0;
    int n_fail   = 0;
    int seq_note[$];
    int seq_dur[$];

    note_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_W(TICK_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_div   (tick_div),
        .start      (start),
        .stop       (stop),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_note    (ev_note),
        .ev_dur     (ev_dur),
        .noteStream (noteStream),
        .note_on    (note_on),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic int model_code(input int c);
        int oct;
        int nt;
        oct = c / 64;
        nt  = c % 64;
        return (oct >= 2 && oct <= 6 && nt >= 1 && nt <= 12) ? c : 0;
    endfunction

    task automatic push(input int n, input int d);
        ev_valid = 1'b1;
        ev_note  = 9'(n);
        ev_dur   = DUR_W'(d);
        step();
        ev_valid = 1'b0;
    endtask

    task automatic do_stop(input string tag);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check({tag, " stop busy"}, 32'(busy), 0);
        check({tag, " stop ns"}, 32'(noteStream), 0);
        check({tag, " stop ready"}, 32'(ev_ready), 1);
    endtask

    // Preload seq_note/seq_dur, start, and compare every cycle with the timeline.
    task automatic run_seq(input string tag, input int td);
        int tdm;
        int len;
        int code;
        int exp_q[$];
        tick_div = TICK_W'(td);
        tdm = (td == 0) ? 1 : td;
        foreach (seq_note[i]) push(seq_note[i], seq_dur[i]);
        if (seq_note.size() == DEPTH) begin
            check({tag, " full ready"}, 32'(ev_ready), 0);
            push(9'h101, 1);
        end
        foreach (seq_note[i]) begin
            len  = ((seq_dur[i] == 0) ? 1 : seq_dur[i]) * tdm;
            code = model_code(seq_note[i]);
            repeat (len) exp_q.push_back(code);
            if (GAP_ON) repeat (tdm) exp_q.push_back(0);
        end
        repeat (3) exp_q.push_back(0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check({tag, " first underrun"}, 32'(underrun), 0);
        check({tag, " first ready"}, 32'(ev_ready), 1);
        check({tag, " first busy"}, 32'(busy), 1);
        foreach (exp_q[k]) begin
            if (k > 0) step();
            check($sformatf("%s ns[%0d]", tag, k), 32'(noteStream), 32'(exp_q[k]));
            check($sformatf("%s on[%0d]", tag, k), 32'(note_on), 32'(exp_q[k] != 0));
        end
        step();
        check({tag, " end underrun"}, 32'(underrun), 1);
        check({tag, " end ns"}, 32'(noteStream), 0);
        do_stop(tag);
        seq_note.delete();
        seq_dur.delete();
    endtask

    initial begin
        int n;
        int c;
        reset    = 1'b1;
        tick_div = '0;
        start    = 1'b0;
        stop     = 1'b0;
        ev_valid = 1'b0;
        ev_note  = '0;
        ev_dur   = '0;
        step();
        step();
        reset = 1'b0;
        check("rst ns", 32'(noteStream), 0);
        check("rst on", 32'(note_on), 0);
        check("rst busy", 32'(busy), 0);
        check("rst underrun", 32'(underrun), 0);
        check("rst ready", 32'(ev_ready), 1);

        seq_note = '{'h10A};
        seq_dur  = '{3};
        run_seq("a4", 4);

        seq_note = '{'h101, 'h14C};
        seq_dur  = '{1, 2};
        run_seq("b2b", 2);

        seq_note = '{'h1CD, 'h10D, 'h0};
        seq_dur  = '{2, 3, 1};
        run_seq("invalid", 2);

        for (int i = 0; i < DEPTH; i++) begin
            seq_note.push_back(int'($urandom_range(511, 0)));
            seq_dur.push_back(int'($urandom_range(3, 0)));
        end
        run_seq("fill", 1);

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(DEPTH, 1));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(1, 0) == 1)
                    c = int'($urandom_range(6, 2)) * 64 + int'($urandom_range(12, 1));
                else
                    c = int'($urandom_range(511, 0));
                seq_note.push_back(c);
                seq_dur.push_back(int'($urandom_range(3, 0)));
            end
            run_seq($sformatf("rnd%0d", r), int'($urandom_range(3, 0)));
        end

        // Stop mid-note with start and a push in the same cycle.
        tick_div = TICK_W'(4);
        push('h10A, 5);
        push('h14C, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        check("mid ns", 32'(noteStream), 32'h10A);
        stop     = 1'b1;
        start    = 1'b1;
        ev_valid = 1'b1;
        ev_note  = 9'h101;
        ev_dur   = 8'd1;
        step();
        stop     = 1'b0;
        start    = 1'b0;
        ev_valid = 1'b0;
        check("stop busy", 32'(busy), 0);
        check("stop ns", 32'(noteStream), 0);
        check("stop on", 32'(note_on), 0);
        check("stop underrun", 32'(underrun), 0);
        check("stop ready", 32'(ev_ready), 1);
        step();
        check("stop idle busy", 32'(busy), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("flushed ns", 32'(noteStream), 0);
        check("flushed underrun", 32'(underrun), 1);
        check("flushed busy", 32'(busy), 1);
        do_stop("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
